// File: rtl/full_adder_pkg.sv
// Shared constants for the registered ripple-carry adder.
// WIDTH defaults to the single-bit adder. The legal range is 1 to 64.
package full_adder_pkg;
  localparam int FA_DEFAULT_WIDTH = 1;
  localparam int FA_MAX_WIDTH     = 64;
endpackage

// File: rtl/full_adder_if.sv
// Operand and result bundle for full_adder.
// Handshake: in_valid marks the operands valid on this clock edge, and out_valid
// marks the result valid one cycle later. There is no ready signal, so the
// consumer must accept every valid result.
interface full_adder_if
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
) ();
  logic             in_valid;
  logic [WIDTH-1:0] inp1;
  logic [WIDTH-1:0] inp2;
  logic             carryin;
  logic [WIDTH-1:0] sum;
  logic             carryout;
  logic             out_valid;

  modport master (
    output in_valid, inp1, inp2, carryin,
    input  sum, carryout, out_valid
  );

  modport slave (
    input  in_valid, inp1, inp2, carryin,
    output sum, carryout, out_valid
  );
endinterface

// File: rtl/full_adder_fa_cell.sv
// Combinational 1-bit full adder cell.
// It is the link in the ripple chain of full_adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic w_p;

  assign w_p = a ^ b;
  assign s   = w_p ^ ci;
  assign co  = (a & b) | (ci & w_p);
endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit adder: a ripple chain of fa_cell feeds one output register stage.
// Held results survive idle cycles; only out_valid drops when in_valid is low.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  full_adder_if.slave   bus
);
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_valid;

  assign w_c[0] = bus.carryin;

  for (genvar g = 0; g < WIDTH; g++) begin : g_chain
    fa_cell u_cell (
      .a  (bus.inp1[g]),
      .b  (bus.inp2[g]),
      .ci (w_c[g]),
      .s  (w_s[g]),
      .co (w_c[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_sum   <= w_s;
        r_carry <= w_c[WIDTH];
      end
    end
  end

  assign bus.sum       = r_sum;
  assign bus.carryout  = r_carry;
  assign bus.out_valid = r_valid;
endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder at WIDTH=1 and WIDTH=8 driven in lockstep.
// Expected results come from an arithmetic model, pass through a queue and are checked one edge later.
module tb_full_adder;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  full_adder_if #(.WIDTH(1)) bus1 ();
  full_adder_if #(.WIDTH(8)) bus8 ();

  full_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  full_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

  // Expected queues hold {out_valid, carryout, sum}.
  logic [2:0] exp_q1[$];
  logic [9:0] exp_q8[$];

  logic       m1_sum, m1_co, m1_ov;
  logic [7:0] m8_sum;
  logic       m8_co, m8_ov;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r,
                      input logic v1, input logic a1, input logic b1, input logic c1,
                      input logic v8, input logic [7:0] a8, input logic [7:0] b8,
                      input logic c8);
    logic [1:0] t1;
    logic [8:0] t8;
    logic [2:0] e1;
    logic [9:0] e8;
    @(negedge clk);
    rst           = r;
    bus1.in_valid = v1;
    bus1.inp1     = a1;
    bus1.inp2     = b1;
    bus1.carryin  = c1;
    bus8.in_valid = v8;
    bus8.inp1     = a8;
    bus8.inp2     = b8;
    bus8.carryin  = c8;
    t1 = {1'b0, a1} + {1'b0, b1} + {1'b0, c1};
    t8 = {1'b0, a8} + {1'b0, b8} + {8'd0, c8};
    if (r) begin
      m1_sum = 1'b0; m1_co = 1'b0; m1_ov = 1'b0;
      m8_sum = 8'h00; m8_co = 1'b0; m8_ov = 1'b0;
    end else begin
      m1_ov = v1;
      m8_ov = v8;
      if (v1) begin m1_sum = t1[0]; m1_co = t1[1]; end
      if (v8) begin m8_sum = t8[7:0]; m8_co = t8[8]; end
    end
    exp_q1.push_back({m1_ov, m1_co, m1_sum});
    exp_q8.push_back({m8_ov, m8_co, m8_sum});
    @(posedge clk);
    #1;
    e1 = exp_q1.pop_front();
    e8 = exp_q8.pop_front();
    check("w1_sum",       64'(bus1.sum),       64'(e1[0]));
    check("w1_carryout",  64'(bus1.carryout),  64'(e1[1]));
    check("w1_out_valid", 64'(bus1.out_valid), 64'(e1[2]));
    check("w8_sum",       64'(bus8.sum),       64'(e8[7:0]));
    check("w8_carryout",  64'(bus8.carryout),  64'(e8[8]));
    check("w8_out_valid", 64'(bus8.out_valid), 64'(e8[9]));
  endtask

  initial begin
    logic [2:0] combo;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus1.in_valid = 1'b0; bus1.inp1 = '0; bus1.inp2 = '0; bus1.carryin = 1'b0;
    bus8.in_valid = 1'b0; bus8.inp1 = '0; bus8.inp2 = '0; bus8.carryin = 1'b0;
    m1_sum = 1'b0; m1_co = 1'b0; m1_ov = 1'b0;
    m8_sum = 8'h00; m8_co = 1'b0; m8_ov = 1'b0;

    // Reset for two cycles with random inputs.
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    // Directed corners: 0+1, 1+1, 1+1+1 / FF+01, FF+FF+1, 12+34 then hold.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h01, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 8'h34, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h5A, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h77, 8'h99, 1'b0);

    // All 8 single-bit combinations back-to-back, with a reset cut in mid-sequence.
    for (int i = 0; i < 8; i++) begin
      combo = 3'(i);
      if (i == 4)
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
      step(1'b0, 1'b1, combo[2], combo[1], combo[0],
           1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), combo[0]);
    end

    // Random traffic with sparse resets and idle cycles.
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    check("queue1_drained", 64'(exp_q1.size()), 64'd0);
    check("queue8_drained", 64'(exp_q8.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
